// File: rtl/inert_spi_resp.sv
// inert_spi_resp: SPI mode-0 responder modelling the inertial sensor port (`INERT_RESP_WHOAMI_EN adds WHO_AM_I at 0x0F)
module inert_spi_resp #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_in,
    input  logic        ptch_vld,
    output logic        frm_done
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic        ss_hist_q, sclk_hist_q;
    logic        ss_s, sclk_s, mosi_s;
    logic        ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic        frame_end, commit, shadow_load, rd_23;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shft_q, rx_shft_d;
    logic [7:0]  tx_shft_q, tx_shft_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  int_cfg_q, int_cfg_d, reg10_q, reg10_d, reg11_q, reg11_d, reg14_q, reg14_d;
    logic [15:0] ptch_q, ptch_d, pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        int_q, int_d, frm_done_q, frm_done_d;
    logic [7:0]  rd_data;

    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // history resets low so SS_n must be seen high before a fall can start a frame
    assign ss_rise   = ss_s & ~ss_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;

    assign frame_end   = ss_rise & (state_q != IDLE);
    assign commit      = frame_end & (bit_cnt_q == 5'd16);
    assign rd_23       = commit & rw_q & (addr_q == 7'h23);
    assign shadow_load = (ptch_vld & (state_q == IDLE)) | (frame_end & (ptch_vld | pend_vld_q));

    assign MISO     = (state_q == DATA) & tx_shft_q[7];
    assign INT      = int_q;
    assign frm_done = frm_done_q;

    // synchronize the SPI pins and keep one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_hist_q   <= 1'b0;
            sclk_hist_q <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_hist_q   <= ss_s;
            sclk_hist_q <= sclk_s;
        end
    end

    // read mux for the register file, evaluated once the address is latched
    always_comb begin
        case (addr_q)
            7'h0D:   rd_data = int_cfg_q;
`ifdef INERT_RESP_WHOAMI_EN
            7'h0F:   rd_data = 8'h6A;
`endif
            7'h10:   rd_data = reg10_q;
            7'h11:   rd_data = reg11_q;
            7'h14:   rd_data = reg14_q;
            7'h22:   rd_data = ptch_q[7:0];
            7'h23:   rd_data = ptch_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // frame FSM, register file commit, sample shadowing and INT
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shft_d  = rx_shft_q;
        tx_shft_d  = tx_shft_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        int_cfg_d  = int_cfg_q;
        reg10_d    = reg10_q;
        reg11_d    = reg11_q;
        reg14_d    = reg14_q;
        ptch_d     = ptch_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        frm_done_d = commit;
        int_d      = (shadow_load & int_cfg_q[1]) | (int_q & ~rd_23);
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    bit_cnt_d = '0;
                    rx_shft_d = '0;
                    tx_shft_d = '0;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        rw_d   = rx_shft_q[6];
                        addr_d = {rx_shft_q[5:0], mosi_s};
                    end
                end
                if (sclk_fall && bit_cnt_q == 5'd8) begin
                    tx_shft_d = rw_q ? rd_data : 8'h00;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (sclk_rise && bit_cnt_q != 5'd16) begin
                    rx_shft_d = {rx_shft_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall)
                    tx_shft_d = {tx_shft_q[6:0], 1'b0};
            end
            default: state_d = IDLE;
        endcase
        if (ss_rise)
            state_d = IDLE;
        if (commit && !rw_q) begin
            case (addr_q)
                7'h0D:   int_cfg_d = rx_shft_q;
                7'h10:   reg10_d   = rx_shft_q;
                7'h11:   reg11_d   = rx_shft_q;
                7'h14:   reg14_d   = rx_shft_q;
                default: ;
            endcase
        end
        // samples arriving mid-frame are parked so 0x22/0x23 never tear; newest wins
        if (ptch_vld && state_q == IDLE)
            ptch_d = ptch_in;
        else if (frame_end) begin
            ptch_d     = ptch_vld ? ptch_in : (pend_vld_q ? pend_q : ptch_q);
            pend_vld_d = 1'b0;
        end else if (ptch_vld) begin
            pend_d     = ptch_in;
            pend_vld_d = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shft_q  <= '0;
            tx_shft_q  <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            int_cfg_q  <= '0;
            reg10_q    <= '0;
            reg11_q    <= '0;
            reg14_q    <= '0;
            ptch_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            int_q      <= 1'b0;
            frm_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shft_q  <= rx_shft_d;
            tx_shft_q  <= tx_shft_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            int_cfg_q  <= int_cfg_d;
            reg10_q    <= reg10_d;
            reg11_q    <= reg11_d;
            reg14_q    <= reg14_d;
            ptch_q     <= ptch_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            int_q      <= int_d;
            frm_done_q <= frm_done_d;
        end
    end
endmodule

// File: tb/tb_inert_spi_resp.sv
// tb_inert_spi_resp: directed bench for the inertial sensor SPI responder
module tb_inert_spi_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO, INT, frm_done;
    logic [15:0] ptch_in = '0;
    logic        ptch_vld = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          fd_cnt = 0;
    int          miso_cnt = 0;
    int          fd0, mi0;
    logic [15:0] r;

    inert_spi_resp #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .INT(INT), .ptch_in(ptch_in), .ptch_vld(ptch_vld), .frm_done(frm_done)
    );

    always #5 clk = ~clk;

    // count frm_done cycles and MISO-high cycles, sampled off the active edge
    always @(negedge clk) begin
        if (frm_done) fd_cnt++;
        if (MISO) miso_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // mode-0 master frame at clk/32; optional ptch_vld pulse before bit pa
    task automatic spi(input logic [15:0] w, input int n, input int pa, input logic [15:0] pv,
                       output logic [15:0] rd);
        rd = '0;
        SS_n = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            MOSI = w[15-i];
            if (i == pa) begin
                ptch_in = pv;
                ptch_vld = 1'b1;
                @(negedge clk);
                ptch_vld = 1'b0;
            end
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            rd = {rd[14:0], MISO};
            repeat (16) @(negedge clk);
            SCLK = 1'b0;
            repeat (8) @(negedge clk);
        end
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse(input logic [15:0] v);
        ptch_in = v;
        ptch_vld = 1'b1;
        @(negedge clk);
        ptch_vld = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_miso", {15'd0, MISO}, 16'd0);
        chk("rst_int", {15'd0, INT}, 16'd0);
        chk("rst_fd", {15'd0, frm_done}, 16'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_fd", fd_cnt[15:0], 16'd0);

        fd0 = fd_cnt; mi0 = miso_cnt;
        spi(16'h0D02, 16, -1, 16'h0, r);
        chk("wr0d_fd", 16'(fd_cnt - fd0), 16'd1);
        chk("wr0d_miso", 16'(miso_cnt - mi0), 16'd0);
        chk("wr0d_rx", r, 16'h0000);
        spi(16'h8D00, 16, -1, 16'h0, r);
        chk("rd0d", r, 16'h0002);

        chk("int_pre", {15'd0, INT}, 16'd0);
        pulse(16'h1234);
        chk("int_set", {15'd0, INT}, 16'd1);
        spi(16'hA200, 16, -1, 16'h0, r);
        chk("rd22", r, 16'h0034);
        chk("int_hold", {15'd0, INT}, 16'd1);
        spi(16'hA300, 16, -1, 16'h0, r);
        chk("rd23", r, 16'h0012);
        chk("int_clr", {15'd0, INT}, 16'd0);

        spi(16'hA300, 16, 4, 16'hBEEF, r);
        chk("rd23_mid", r, 16'h0012);
        chk("int_setwins", {15'd0, INT}, 16'd1);
        spi(16'hA200, 16, -1, 16'h0, r);
        chk("rd22_new", r, 16'h00EF);
        spi(16'hA300, 16, -1, 16'h0, r);
        chk("rd23_new", r, 16'h00BE);
        chk("int_clr2", {15'd0, INT}, 16'd0);

        fd0 = fd_cnt;
        spi(16'h1053, 10, -1, 16'h0, r);
        chk("abort_fd", 16'(fd_cnt - fd0), 16'd0);
        spi(16'h9000, 16, -1, 16'h0, r);
        chk("abort_r10", r, 16'h0000);
        fd0 = fd_cnt;
        spi(16'h1053, 16, -1, 16'h0, r);
        chk("wr10_fd", 16'(fd_cnt - fd0), 16'd1);
        spi(16'h9000, 16, -1, 16'h0, r);
        chk("rd10", r, 16'h0053);
        spi(16'h11A5, 16, -1, 16'h0, r);
        spi(16'h143C, 16, -1, 16'h0, r);
        spi(16'h9100, 16, -1, 16'h0, r);
        chk("rd11", r, 16'h00A5);
        spi(16'h9400, 16, -1, 16'h0, r);
        chk("rd14", r, 16'h003C);
        spi(16'h15FF, 16, -1, 16'h0, r);
        spi(16'h9500, 16, -1, 16'h0, r);
        chk("rd15_unmapped", r, 16'h0000);

        pulse(16'h7777);
        chk("int_set2", {15'd0, INT}, 16'd1);
        spi(16'h0D00, 16, -1, 16'h0, r);
        chk("int_cfg_off_keeps", {15'd0, INT}, 16'd1);
        spi(16'hA300, 16, -1, 16'h0, r);
        chk("rd23_77", r, 16'h0077);
        chk("int_clr3", {15'd0, INT}, 16'd0);
        pulse(16'hC33C);
        chk("int_disabled", {15'd0, INT}, 16'd0);
        spi(16'hA200, 16, -1, 16'h0, r);
        chk("rd22_dis", r, 16'h003C);
        spi(16'hA300, 16, -1, 16'h0, r);
        chk("rd23_dis", r, 16'h00C3);

        spi(16'h8F00, 16, -1, 16'h0, r);
`ifdef INERT_RESP_WHOAMI_EN
        chk("whoami", r, 16'h006A);
`else
        chk("whoami", r, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
